// File: rtl/instr_fetch_responder_pkg.sv
// Shared sizing, FSM encodings and constants for the instruction fetch responder.
package instr_fetch_responder_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int INSTR_W   = 32;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_responder_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
module instr_ram
  import instr_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instr_fetch_responder.sv
// Byte-serial program loader feeding a zero-latency instruction store; PC is held
// (halt) until a complete program has been loaded.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int MEM_DEPTH = instr_fetch_responder_pkg::MEM_DEPTH,
  parameter int ADDR_W    = instr_fetch_responder_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       adressIn,
  output logic [31:0]       instruction,
  output logic              halt,
  input  logic              loadValid,
  input  logic [7:0]        loadByte,
  input  logic              loadLast,
  output logic              loadReady,
  output logic [ADDR_W:0]   wordCount,
  output logic              loadError
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [1:0]          cnt_q;
  logic [31:0]         asm_q, asm_d;
  logic [ADDR_W:0]     wcnt_q;
  logic                err_q, halt_q, ready_q;
  logic                accept, word_done, we;
  logic [31:0]         rdata;

  assign accept    = loadValid && ready_q;
  assign word_done = accept && (cnt_q == 2'd3);
  // Byte lands in its big-endian slot directly, so the full word is ready on the 4th byte.
  assign asm_d     = asm_q | ({24'h0, loadByte} << (5'd8 * {3'd0, 2'd3 - cnt_q}));
  assign we        = word_done && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      asm_q    <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      halt_q   <= 1'b1;
      ready_q  <= 1'b1;
    end else if (accept) begin
      cnt_q <= cnt_q + 2'd1;
      asm_q <= asm_d;
      if (cnt_q == 2'd3) begin
        asm_q  <= '0;
        wcnt_q <= wcnt_q + 1'b1;
        if (wr_ptr_q != LAST_PTR) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (loadLast) begin
          state_q <= S_RUN;
          halt_q  <= 1'b0;
          ready_q <= 1'b0;
        end else if (wr_ptr_q == LAST_PTR) begin
          state_q <= S_FAULT;
          err_q   <= 1'b1;
          ready_q <= 1'b0;
        end
      end else if (loadLast) begin
        // Truncated program: drop the partial word.
        cnt_q   <= '0;
        asm_q   <= '0;
        state_q <= S_FAULT;
        err_q   <= 1'b1;
        ready_q <= 1'b0;
      end
    end
  end

  instr_ram #(.DEPTH(MEM_DEPTH), .AW(ADDR_W)) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (asm_d),
    .raddr_i (adressIn[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  // Anything not yet written since reset (including stale words) reads as nop.
  assign instruction = (state_q == S_RUN && adressIn < 32'(wcnt_q)) ? rdata : NOP_WORD;
  assign halt        = halt_q;
  assign loadReady   = ready_q;
  assign wordCount   = wcnt_q;
  assign loadError   = err_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench: byte streams vs. a word-level reference model of the loader.
module tb_instr_fetch_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adressIn = '0;
  logic [31:0] instruction;
  logic        halt, loadValid = 1'b0, loadLast = 1'b0, loadReady, loadError;
  logic [7:0]  loadByte = '0;
  logic [8:0]  wordCount;

  int errors = 0;
  int checks = 0;

  logic [7:0]  bq[$];
  logic [31:0] mdl_mem [256];
  int          mdl_cnt;

  always #5 clock = ~clock;

  instr_fetch_responder #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .adressIn(adressIn), .instruction(instruction),
    .halt(halt), .loadValid(loadValid), .loadByte(loadByte), .loadLast(loadLast),
    .loadReady(loadReady), .wordCount(wordCount), .loadError(loadError)
  );

  // Reference: program words are the byte stream taken four at a time, big-endian.
  function automatic void model_words();
    mdl_cnt = bq.size() / 4;
    if (mdl_cnt > 256) mdl_cnt = 256;
    for (int i = 0; i < mdl_cnt; i++)
      mdl_mem[i] = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clock);
    loadValid = 1'b1; loadByte = b; loadLast = last;
    @(posedge clock); #1;
    loadValid = 1'b0; loadLast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic present_byte);
    @(negedge clock);
    reset = 1'b1; loadValid = present_byte; loadByte = 8'hAA; loadLast = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; loadValid = 1'b0;
  endtask

  task automatic stream(input bit last, input int max_gap);
    for (int i = 0; i < bq.size(); i++) begin
      send_byte(bq[i], last && (i == bq.size() - 1));
      if (max_gap > 0) idle($urandom_range(max_gap, 1));
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    @(negedge clock);
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b want 1", halt); end
    checks++; if (loadReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", loadReady); end
    checks++; if (wordCount !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", wordCount); end
    checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", loadError); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instruction); end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00};
    stream(1'b0, 0);
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL basic_halt_pre: got %b want 1", halt); end
    bq.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    model_words();
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL basic_halt_post: got %b want 0", halt); end
    checks++; if (wordCount !== 9'(mdl_cnt)) begin errors++; $display("FAIL basic_count: got %0d want %0d", wordCount, mdl_cnt); end
    for (int a = 0; a < 3; a++) begin
      adressIn = a; #1;
      checks++;
      if (instruction !== (a < mdl_cnt ? mdl_mem[a] : 32'h0)) begin
        errors++; $display("FAIL basic_read[%0d]: got %h want %h", a, instruction, (a < mdl_cnt ? mdl_mem[a] : 32'h0));
      end
    end
    checks++; if (mdl_mem[0] !== 32'h2008_0005 || mdl_mem[1] !== 32'h2009_0007) begin
      errors++; $display("FAIL basic_model: got %h %h want 20080005 20090007", mdl_mem[0], mdl_mem[1]);
    end
  endtask

  task automatic test_gaps();
    do_reset(1'b0);
    bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    for (int i = 0; i < 8; i++) begin
      send_byte(bq[i], i == 7);
      idle(1);
    end
    model_words();
    checks++; if (wordCount !== 9'(mdl_cnt)) begin errors++; $display("FAIL gaps_count: got %0d want %0d", wordCount, mdl_cnt); end
    for (int a = 0; a < 2; a++) begin
      adressIn = a; #1;
      checks++; if (instruction !== mdl_mem[a]) begin errors++; $display("FAIL gaps_read[%0d]: got %h want %h", a, instruction, mdl_mem[a]); end
    end
  endtask

  task automatic test_run_ignore();
    adressIn = 32'h0000_0100; #1;
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL run_oob: got %h want 0", instruction); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL run_ready: got %b want 0", loadReady); end
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'(i == 4));
    checks++; if (wordCount !== 9'(mdl_cnt)) begin errors++; $display("FAIL run_ignore_count: got %0d want %0d", wordCount, mdl_cnt); end
    checks++; if (halt !== 1'b0 || loadError !== 1'b0) begin errors++; $display("FAIL run_ignore_state: got halt=%b err=%b want 0 0", halt, loadError); end
    adressIn = 0; #1;
    checks++; if (instruction !== mdl_mem[0]) begin errors++; $display("FAIL run_ignore_mem: got %h want %h", instruction, mdl_mem[0]); end
  endtask

  task automatic test_reset_midload();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    do_reset(1'b1);
    checks++; if (wordCount !== 9'd0 || halt !== 1'b1) begin errors++; $display("FAIL midload_reset: got count=%0d halt=%b want 0 1", wordCount, halt); end
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    stream(1'b1, 0);
    model_words();
    adressIn = 0; #1;
    checks++; if (instruction !== mdl_mem[0]) begin errors++; $display("FAIL midload_word0: got %h want %h", instruction, mdl_mem[0]); end
    adressIn = 1; #1;
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL midload_word1: got %h want 0", instruction); end
    checks++; if (wordCount !== 9'd1) begin errors++; $display("FAIL midload_count: got %0d want 1", wordCount); end
  endtask

  task automatic test_fault_partial();
    do_reset(1'b0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    stream(1'b1, 0);
    model_words();
    adressIn = 0; #1;
    checks++; if (loadError !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL partial_flags: got err=%b halt=%b want 1 1", loadError, halt); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL partial_instr: got %h want 0", instruction); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL partial_ready: got %b want 0", loadReady); end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'(i == 7));
    checks++; if (wordCount !== 9'(mdl_cnt)) begin errors++; $display("FAIL partial_count: got %0d want %0d", wordCount, mdl_cnt); end
    checks++; if (loadError !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL partial_sticky: got err=%b halt=%b want 1 1", loadError, halt); end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    bq.delete();
    for (int i = 0; i < 1024; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < 1020; i++) send_byte(bq[i], 1'b0);
    checks++; if (loadError !== 1'b0 || wordCount !== 9'd255) begin errors++; $display("FAIL ovf_pre: got err=%b count=%0d want 0 255", loadError, wordCount); end
    for (int i = 1020; i < 1024; i++) send_byte(bq[i], 1'b0);
    model_words();
    checks++; if (wordCount !== 9'(mdl_cnt)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", wordCount, mdl_cnt); end
    checks++; if (loadError !== 1'b1 || halt !== 1'b1 || loadReady !== 1'b0) begin
      errors++; $display("FAIL ovf_flags: got err=%b halt=%b ready=%b want 1 1 0", loadError, halt, loadReady);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int nw;
      do_reset(1'b0);
      nw = $urandom_range(20, 1);
      bq.delete();
      for (int i = 0; i < 4*nw; i++) bq.push_back(8'($urandom));
      stream(1'b1, t % 2 ? 2 : 0);
      model_words();
      checks++; if (wordCount !== 9'(mdl_cnt) || halt !== 1'b0) begin
        errors++; $display("FAIL rand%0d_state: got count=%0d halt=%b want %0d 0", t, wordCount, halt, mdl_cnt);
      end
      for (int k = 0; k < 12; k++) begin
        logic [31:0] a, exp;
        a = (k % 4 == 3) ? $urandom : 32'($urandom_range(25, 0));
        exp = (a < 32'(mdl_cnt)) ? mdl_mem[a] : 32'h0;
        adressIn = a; #1;
        checks++; if (instruction !== exp) begin errors++; $display("FAIL rand%0d_read[%h]: got %h want %h", t, a, instruction, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_run_ignore();
    test_reset_midload();
    test_fault_partial();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, instruction words held.
REQ-002 SHALL have parameter ADDR_W, default 8, word-index width (log2 MEM_DEPTH).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port adressIn  input  32  word address from the program counter (increments by 1 per instruction).
REQ-006 SHALL have port instruction  output  32  instruction word returned for adressIn.
REQ-007 SHALL have port halt  output  1  freeze request to the program counter; 1 = PC holds.
REQ-008 SHALL have port loadValid  input  1  loader byte valid.
REQ-009 SHALL have port loadByte  input  8  program byte, big-endian within each word.
REQ-010 SHALL have port loadLast  input  1  marks the final byte of the program; qualified by loadValid.
REQ-011 SHALL have port loadReady  output  1  block accepts a byte this cycle.
REQ-012 SHALL have port wordCount  output  ADDR_W+1  number of words written since reset.
REQ-013 SHALL have port loadError  output  1  sticky fault flag.

Function
REQ-014 SHALL implement FSM states LOAD, RUN, FAULT; reset enters LOAD.
REQ-015 A byte SHALL be accepted only when loadValid && loadReady on a rising edge; loadReady = 1 in LOAD only.
REQ-016 In LOAD, accepted bytes SHALL shift into a 32-bit assembler, first byte ending in bits [31:24]; a 2-bit byte counter SHALL count 0..3 and wrap.
REQ-017 On the 4th accepted byte the assembled word (including that byte) SHALL be written to mem[wrPtr] in the same edge, wrPtr and wordCount SHALL increment by 1.
REQ-018 loadLast on a byte completing a word (counter==3) SHALL write that word and move to RUN on the same edge.
REQ-019 loadLast on a byte with counter!=3 SHALL discard the partial word, set loadError, and move to FAULT.
REQ-020 A completed word written at wrPtr==MEM_DEPTH-1 without loadLast SHALL still be written, set loadError, and move to FAULT; wrPtr SHALL NOT wrap.
REQ-021 loadValid with loadReady=0 (RUN/FAULT) SHALL be ignored with no state change.
REQ-022 halt SHALL be 1 in LOAD and FAULT, 0 in RUN, driven from registered state (no combinational path from load inputs).
REQ-023 In RUN, instruction SHALL equal mem[adressIn[ADDR_W-1:0]] combinationally (zero-latency read, single-cycle datapath).
REQ-024 In RUN, adressIn >= wordCount SHALL return 32'h0000_0000 (nop); addresses at or above MEM_DEPTH fall under this rule.
REQ-025 In LOAD and FAULT, instruction SHALL be 32'h0000_0000.
REQ-026 loadError SHALL stay 1 until reset; FAULT SHALL be exited only by reset.

Reset
REQ-027 On reset: state=LOAD, wrPtr=0, byte counter=0, assembler=0, wordCount=0, loadError=0, halt=1, loadReady=1, instruction=0.
REQ-028 Reset SHALL NOT clear memory contents; stale words are masked by REQ-024.
REQ-029 Reset mid-load SHALL discard any partial word; a byte presented in the reset cycle SHALL NOT be accepted.
REQ-030 Reset in RUN SHALL return to LOAD, raising halt on the next cycle.

Structure
REQ-031 Shared package SHALL hold MEM_DEPTH, ADDR_W, state encodings (LOAD=2'd0, RUN=2'd1, FAULT=2'd2), and the NOP word constant.
REQ-032 Storage SHALL be a sub-module instr_ram: MEM_DEPTH x 32, one synchronous write port, one asynchronous read port.
REQ-033 FSM, byte assembler, and range check SHALL reside in instr_fetch_responder.

Verification
REQ-034 Load bytes 20,08,00,05 | 20,09,00,07 with loadLast on the 8th byte -> wordCount=2, halt falls the cycle after the 8th byte, adressIn=0/1/2 -> 20080005 / 20090007 / 00000000.
REQ-035 loadValid toggled 1,0,1,0 across bytes (gaps) -> same words written; no byte lost or duplicated.
REQ-036 loadLast on the 3rd byte of a word -> loadError=1, state FAULT, halt=1, instruction=0, further bytes ignored.
REQ-037 Stream 256 full words without loadLast -> word 255 written, loadError=1, FAULT, wordCount=256.
REQ-038 Reset after 6 bytes (1.5 words) -> wordCount=0, halt=1; reload 1 word with loadLast -> only that word readable at address 0, address 1 -> 0.
REQ-039 In RUN, drive adressIn=32'h0000_0100 -> instruction=0; loadValid pulses -> loadReady=0, wordCount unchanged.
